// File: rtl/divider_seq.sv
// Sequential FP32 divider: restoring radix-2 division on 24-bit significands,
// one quotient bit per clock, fixed latency, truncating, with overflow/underflow flags.
module divider_seq #(
  parameter int QBITS = 25,
  parameter int EXPW  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] S,
  output logic        overflag,
  output logic        underflag
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [25:0]      rem_q, rem_d;
  logic [QBITS-1:0] quo_q, quo_d;
  logic [23:0]      fracb_q, fracb_d;
  logic [7:0]       expa_q, expa_d;
  logic [7:0]       expb_q, expb_d;
  logic             sign_q, sign_d;
  logic [31:0]      s_q, s_d;
  logic             over_q, over_d;
  logic             under_q, under_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [25:0]        trial_s;
  logic               ge_s;
  logic signed [EXPW-1:0] exp_s;
  logic [22:0]        frac_s;

  // Next-state, datapath iteration and result normalisation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    fracb_d = fracb_q;
    expa_d  = expa_q;
    expb_d  = expb_q;
    sign_d  = sign_q;
    s_d     = s_q;
    over_d  = over_q;
    under_d = under_q;
    done_d  = 1'b0;

    // Compare before shifting so the first bit lands in Q[24]: Q = floor(fracA*2^24/fracB).
    trial_s = rem_q - {2'b00, fracb_q};
    ge_s    = (rem_q >= {2'b00, fracb_q});

    exp_s = $signed({{(EXPW-8){1'b0}}, expa_q}) - $signed({{(EXPW-8){1'b0}}, expb_q})
          + (quo_q[QBITS-1] ? $signed(EXPW'(127)) : $signed(EXPW'(126)));
    if (quo_q[QBITS-1]) begin
      frac_s = quo_q[23:1];
    end else begin
      frac_s = quo_q[22:0];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = A[31] ^ B[31];
          expa_d  = A[30:23];
          expb_d  = B[30:23];
          rem_d   = {2'b00, 1'b1, A[22:0]};
          fracb_d = {1'b1, B[22:0]};
          quo_d   = {QBITS{1'b0}};
          cnt_d   = 5'd0;
          over_d  = 1'b0;
          under_d = 1'b0;
          state_d = DIV;
        end else begin
          state_d = IDLE;
        end
      end
      DIV: begin
        if (ge_s) begin
          rem_d = {trial_s[24:0], 1'b0};
        end else begin
          rem_d = {rem_q[24:0], 1'b0};
        end
        quo_d = {quo_q[QBITS-2:0], ge_s};
        if (cnt_q == 5'd24) begin
          cnt_d   = 5'd0;
          state_d = NORM;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = DIV;
        end
      end
      NORM: begin
        if (expb_q == 8'd0) begin
          s_d    = {sign_q, 8'hFF, 23'd0};
          over_d = 1'b1;
        end else if (expa_q == 8'd0) begin
          s_d = {sign_q, 31'd0};
        end else if (exp_s >= $signed(EXPW'(255))) begin
          s_d    = {sign_q, 8'hFF, 23'd0};
          over_d = 1'b1;
        end else if (exp_s <= $signed(EXPW'(0))) begin
          s_d     = {sign_q, 31'd0};
          under_d = 1'b1;
        end else begin
          s_d = {sign_q, exp_s[7:0], frac_s};
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 26'd0;
      quo_q   <= {QBITS{1'b0}};
      fracb_q <= 24'd0;
      expa_q  <= 8'd0;
      expb_q  <= 8'd0;
      sign_q  <= 1'b0;
      s_q     <= 32'd0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      fracb_q <= fracb_d;
      expa_q  <= expa_d;
      expb_q  <= expb_d;
      sign_q  <= sign_d;
      s_q     <= s_d;
      over_q  <= over_d;
      under_q <= under_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign S         = s_q;
  assign overflag  = over_q;
  assign underflag = under_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed self-checking bench for divider_seq: results, flags, latency,
// ignored start while busy, reset abort and back-to-back operation.
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] S;
  logic        overflag, underflag;

  int total = 0;
  int bad   = 0;

  divider_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .S(S), .overflag(overflag), .underflag(underflag)
  );

  always #5 clk = ~clk;

  // Drives one operation; lat is edges from the start edge to done, or -1 on timeout.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({S, done, busy, overflag, underflag} !== 36'd0) begin
      bad++; $display("FAIL reset_outputs: got S=%h d=%b b=%b o=%b u=%b, want all 0",
                      S, done, busy, overflag, underflag);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_s, input logic exp_o, input logic exp_u);
    int lat;
    do_op(a, b, lat);
    total++;
    if (lat !== 26) begin
      bad++; $display("FAIL %s_latency: got %0d, want 26", nm, lat);
    end
    total++;
    if ({S, overflag, underflag} !== {exp_s, exp_o, exp_u}) begin
      bad++; $display("FAIL %s_result: got S=%h o=%b u=%b, want S=%h o=%b u=%b",
                      nm, S, overflag, underflag, exp_s, exp_o, exp_u);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s_busy_at_done: got %b, want 1", nm, busy);
    end
    @(posedge clk); #1;
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL %s_after_done: got done=%b busy=%b, want 0 0", nm, done, busy);
    end
    total++;
    if (S !== exp_s) begin
      bad++; $display("FAIL %s_hold: got S=%h, want %h", nm, S, exp_s);
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    A = 32'h40400000; B = 32'h3FC00000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL ignore_start_pulses: got %0d, want 1", pulses);
    end
    total++;
    if ({S, overflag, underflag} !== {32'h40000000, 2'b00}) begin
      bad++; $display("FAIL ignore_start_result: got S=%h o=%b u=%b, want 40000000 0 0",
                      S, overflag, underflag);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    int lat;
    A = 32'hC0C00000; B = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({S, done, busy, overflag, underflag} !== 36'd0) begin
      bad++; $display("FAIL abort_outputs: got S=%h d=%b b=%b o=%b u=%b, want all 0",
                      S, done, busy, overflag, underflag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_no_done: got pulses=%0d busy=%b, want 0 0", pulses, busy);
    end
    do_op(32'h40400000, 32'h3FC00000, lat);
    total++;
    if (lat !== 26 || S !== 32'h40000000) begin
      bad++; $display("FAIL abort_restart: got lat=%0d S=%h, want 26 40000000", lat, S);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(32'h3F800000, 32'h40400000, lat);
    @(posedge clk); #1;
    do_op(32'hC0C00000, 32'h40000000, lat);
    total++;
    if (lat !== 26 || S !== 32'hC0400000) begin
      bad++; $display("FAIL back_to_back: got lat=%0d S=%h, want 26 c0400000", lat, S);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vec("three_by_1p5", 32'h40400000, 32'h3FC00000, 32'h40000000, 1'b0, 1'b0);
    test_vec("one_third",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0);
    test_vec("neg_six_by_2", 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0);
    test_vec("overflow",     32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 1'b0);
    test_vec("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b1);
    test_vec("div_by_zero",  32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0);
    test_vec("zero_dividend",32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    test_vec("flags_clear",  32'h40400000, 32'h3FC00000, 32'h40000000, 1'b0, 1'b0);
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
